// File: rtl/bcd_scan_display.sv
// Four-digit multiplexed common-anode 7-segment driver fed by cascaded BCD counters.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module bcd_scan_display #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } phase_t;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   sh_dig;
    logic [3:0]    sh_dp;
    logic [3:0]    cur_digit;
    logic [3:0]    lz_blank;
    phase_t        phase;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    // The first BLANK_CYC cycles of every slot keep all anodes dark to hide ghosting.
    always_comb begin
        phase = (cnt < BLANK_END) ? BLANK : DRIVE;
    end

    assign cur_digit = sh_dig[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    // Dash codes are nonzero, so only a true 4'd0 can be suppressed.
    assign lz_blank[3] = (sh_dig[15:12] == 4'd0);
    assign lz_blank[2] = lz_blank[3] && (sh_dig[11:8] == 4'd0);
    assign lz_blank[1] = lz_blank[2] && (sh_dig[7:4] == 4'd0);
    assign lz_blank[0] = 1'b0;
`else
    assign lz_blank = 4'b0000;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            idx    <= 2'd0;
            sh_dig <= 16'h0000;
            sh_dp  <= 4'h0;
            seg_n  <= 7'h7F;
            dp_n   <= 1'b1;
            an_n   <= 4'b1111;
        end else begin
            if (load) begin
                sh_dig <= digits_in;
                sh_dp  <= dp_in;
            end

            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            case (phase)
                DRIVE: begin
                    if (lz_blank[idx]) begin
                        an_n  <= 4'b1111;
                        seg_n <= 7'h7F;
                        dp_n  <= 1'b1;
                    end else begin
                        an_n  <= ~(4'b0001 << idx);
                        seg_n <= decode(cur_digit);
                        dp_n  <= ~sh_dp[idx];
                    end
                end
                default: begin
                    an_n  <= 4'b1111;
                    seg_n <= 7'h7F;
                    dp_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed self-checking bench for bcd_scan_display with SCAN_DIV=8, BLANK_CYC=2.
// Expectations adapt to whether LEADING_ZERO_BLANK_EN is defined for the build.
module tb_bcd_scan_display;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        load;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;

    int tests = 0;
    int fails = 0;

    bcd_scan_display #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk),
        .rst(rst),
        .digits_in(digits_in),
        .dp_in(dp_in),
        .load(load),
        .seg_n(seg_n),
        .dp_n(dp_n),
        .an_n(an_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dp);
        digits_in = d;
        dp_in     = dp;
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    // Bounded wait for a given anode pattern; always advances at least one edge.
    task automatic waitAn(input logic [3:0] want, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (an_n !== want && n < 64);
        checkOutput(tag, an_n, want);
    endtask

    // One full 32-cycle frame: per-digit lit cycles, dp-on cycles, dirty blank cycles.
    task automatic countFrame(output int l0, output int l1, output int l2, output int l3,
                              output int dpOn, output int badBlank);
        l0 = 0; l1 = 0; l2 = 0; l3 = 0; dpOn = 0; badBlank = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            case (an_n)
                4'b1110: l0++;
                4'b1101: l1++;
                4'b1011: l2++;
                4'b0111: l3++;
                default: ;
            endcase
            if (dp_n === 1'b0) dpOn++;
            if (an_n === 4'b1111 && (seg_n !== 7'h7F || dp_n !== 1'b1)) badBlank++;
        end
    endtask

    initial begin
        int l0, l1, l2, l3, dpOn, badBlank;

        rst = 1'b1;
        load = 1'b0;
        digits_in = 16'h0000;
        dp_in = 4'h0;
        tick(); tick(); tick();
        checkOutput("rst_an", an_n, 4'b1111);
        checkOutput("rst_seg", seg_n, 7'h7F);
        checkOutput("rst_dp", dp_n, 1'b1);
        checkOutput("rst_cnt", dut.cnt, 3'd0);
        checkOutput("rst_idx", dut.idx, 2'd0);

        rst = 1'b0;
        tick();
        checkOutput("blank1_an", an_n, 4'b1111);
        tick();
        checkOutput("blank2_an", an_n, 4'b1111);
        tick();
        checkOutput("first_an", an_n, 4'b1110);
        checkOutput("first_seg", seg_n, 7'h40);
        tick(); tick(); tick(); tick(); tick();
        checkOutput("slot0_end_an", an_n, 4'b1110);
        tick();
        checkOutput("slot1_blank_an", an_n, 4'b1111);
        tick();
        checkOutput("slot1_blank2_an", an_n, 4'b1111);
        tick();
        checkOutput("slot1_start_an", an_n, 4'b1101);

        applyStimulus(16'h1905, 4'b0100);
        waitAn(4'b1110, "l1905_s0_an");
        checkOutput("l1905_s0_seg", seg_n, 7'h12);
        checkOutput("l1905_s0_dp", dp_n, 1'b1);
        waitAn(4'b1101, "l1905_s1_an");
        checkOutput("l1905_s1_seg", seg_n, 7'h40);
        waitAn(4'b1011, "l1905_s2_an");
        checkOutput("l1905_s2_seg", seg_n, 7'h10);
        checkOutput("l1905_s2_dp", dp_n, 1'b0);
        waitAn(4'b0111, "l1905_s3_an");
        checkOutput("l1905_s3_seg", seg_n, 7'h79);
        checkOutput("l1905_s3_dp", dp_n, 1'b1);

        applyStimulus(16'h00A3, 4'b0000);
        waitAn(4'b1110, "l00a3_s0_an");
        checkOutput("l00a3_s0_seg", seg_n, 7'h30);
        waitAn(4'b1101, "l00a3_s1_an");
        checkOutput("l00a3_s1_seg", seg_n, 7'h3F);

        applyStimulus(16'h0070, 4'b1111);
        countFrame(l0, l1, l2, l3, dpOn, badBlank);
        checkOutput("l0070_lit0", l0, 6);
        checkOutput("l0070_lit1", l1, 6);
        checkOutput("l0070_lit2", l2, LZB ? 0 : 6);
        checkOutput("l0070_lit3", l3, LZB ? 0 : 6);
        checkOutput("l0070_dpon", dpOn, LZB ? 12 : 24);
        checkOutput("l0070_badblank", badBlank, 0);
        waitAn(4'b1101, "l0070_s1_an");
        checkOutput("l0070_s1_seg", seg_n, 7'h78);
        waitAn(4'b1110, "l0070_s0_an");
        checkOutput("l0070_s0_seg", seg_n, 7'h40);

        applyStimulus(16'h0000, 4'b0000);
        countFrame(l0, l1, l2, l3, dpOn, badBlank);
        checkOutput("l0000_lit0", l0, 6);
        checkOutput("l0000_lit1", l1, LZB ? 0 : 6);
        checkOutput("l0000_lit2", l2, LZB ? 0 : 6);
        checkOutput("l0000_lit3", l3, LZB ? 0 : 6);

        applyStimulus(16'h0A05, 4'b0000);
        countFrame(l0, l1, l2, l3, dpOn, badBlank);
        checkOutput("l0a05_lit1", l1, 6);
        checkOutput("l0a05_lit2", l2, 6);
        checkOutput("l0a05_lit3", l3, LZB ? 0 : 6);
        checkOutput("l0a05_badblank", badBlank, 0);

        applyStimulus(16'h1234, 4'b0000);
        for (int i = 0; i < 64 && !(dut.cnt == 3'd5 && dut.idx == 2'd2); i++) tick();
        checkOutput("mid_reach", {dut.idx, dut.cnt}, {2'd2, 3'd5});
        digits_in = 16'h9999;
        load = 1'b1;
        tick();
        load = 1'b0;
        checkOutput("mid_cap_seg", seg_n, 7'h24);
        checkOutput("mid_cap_an", an_n, 4'b1011);
        tick();
        checkOutput("mid_new_seg", seg_n, 7'h10);
        checkOutput("mid_new_an", an_n, 4'b1011);
        checkOutput("mid_new_cnt", dut.cnt, 3'd7);
        tick();
        checkOutput("mid_wrap_an", an_n, 4'b1011);
        checkOutput("mid_wrap_cnt", dut.cnt, 3'd0);
        checkOutput("mid_wrap_idx", dut.idx, 2'd3);
        tick();
        checkOutput("mid_blank_an", an_n, 4'b1111);

        waitAn(4'b1101, "rl_drive_an");
        rst = 1'b1;
        load = 1'b1;
        digits_in = 16'h5555;
        dp_in = 4'hF;
        tick();
        rst = 1'b0;
        load = 1'b0;
        checkOutput("rl_an", an_n, 4'b1111);
        checkOutput("rl_seg", seg_n, 7'h7F);
        checkOutput("rl_dp", dp_n, 1'b1);
        checkOutput("rl_shdig", dut.sh_dig, 16'h0000);
        checkOutput("rl_shdp", dut.sh_dp, 4'h0);
        checkOutput("rl_cnt", dut.cnt, 3'd0);
        tick(); tick();
        checkOutput("rl_blank_an", an_n, 4'b1111);
        tick();
        checkOutput("rl_first_an", an_n, 4'b1110);
        checkOutput("rl_first_seg", seg_n, 7'h40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Four-digit time-multiplexed 7-segment driver sitting directly downstream of the cascaded 4-bit decade counters. Latches a 16-bit packed BCD value (four counter `out` buses concatenated, most-significant digit in [15:12]) on a load strobe. It then scans the digits onto a common-anode display with a per-slot ghosting blank interval. It converts invalid codes to a dash.

## Interface
- `SCAN_DIV`, default 100000: clock cycles per digit slot; legal range 4..2^20.
- `BLANK_CYC`, default 16: cycles at the start of each slot with all anodes off; must be < `SCAN_DIV`.
- `clk`  in  1: single system clock, all state on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `digits_in`  in  16: packed BCD, digit k in bits [4k+3:4k], digit 3 = most significant.
- `dp_in`  in  4: decimal-point enable per digit, active-high, bit k = digit k.
- `load`  in  1: single-cycle strobe; captures `digits_in`/`dp_in` into shadow registers.
- `seg_n`  out  7: segments {g,f,e,d,c,b,a}, active-low, registered.
- `dp_n`  out  1: decimal point, active-low, registered.
- `an_n`  out  4: anode select, active-low, bit k = digit k, registered.

## Operation
- Shadow registers: `sh_dig[15:0]` and `sh_dp[3:0]` load on any cycle with `load`=1. Otherwise they hold. Display never reads `digits_in` directly.
- Prescaler `cnt` counts 0..`SCAN_DIV`-1. At `cnt`=`SCAN_DIV`-1 it wraps to 0 and slot index `idx` advances 0→1→2→3→0.
- Slot phase FSM, derived from `cnt`:
  - BLANK while `cnt` < `BLANK_CYC`: `an_n`=4'b1111, `seg_n`=7'h7F, `dp_n`=1.
  - DRIVE otherwise: `an_n`=~(1<<`idx`), `seg_n`=decode(digit `idx`), `dp_n`=~`sh_dp[idx]`.
- Decode (active-low): 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10. Codes 10–15 show a dash: `seg_n`=0x3F.
- `load` mid-slot: the new digit value appears from the cycle after capture. `cnt`/`idx` are not disturbed.

## Timing
- Reset values: `an_n`=4'b1111, `seg_n`=7'h7F, `dp_n`=1, `cnt`=0, `idx`=0, `sh_dig`=0, `sh_dp`=0.
- Outputs are registered from the current (`cnt`,`idx`,shadow): one cycle of latency.
- After `rst` is released, `an_n` first goes active (digit 0) at the edge after `cnt` reaches `BLANK_CYC`.
- A full refresh frame is 4×`SCAN_DIV` cycles. Each digit is lit for `SCAN_DIV`-`BLANK_CYC` cycles per frame.
- Visible latency from `load` is 2 edges: capture at edge N, output at edge N+1 if the digit is in DRIVE.
- `rst` mid-slot: all outputs return to reset values on that edge. The shadow value is lost.
- `rst` and `load` asserted on the same cycle: `rst` wins.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: leading zero digits are suppressed.
  - Digit 3 is blanked if it is 0.
  - Digit 2 is blanked if digits 3,2 are 0.
  - Digit 1 is blanked if digits 3..1 are 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps `an_n`=4'b1111 and `seg_n`=7'h7F for its whole slot.
  - `sh_dp` of a blanked digit is ignored.
  - A dash code (≥10) counts as nonzero.
- Undefined: every digit is driven in every DRIVE phase.

## Test plan
Bench parameters: `SCAN_DIV`=8, `BLANK_CYC`=2.
- Reset for 3 cycles, then release with no load. Check: `an_n`=1111 for 2 cycles after release, then 1110 with `seg_n`=0x40, and slot period 8 cycles.
- Load 0x1905 with `dp_in`=4'b0100. Check per slot, with macro undefined:
  - slot 0: `an_n`=1110, `seg_n`=0x12.
  - slot 1: `an_n`=1101, `seg_n`=0x40.
  - slot 2: `an_n`=1011, `seg_n`=0x10, `dp_n`=0.
  - slot 3: `an_n`=0111, `seg_n`=0x79.
- Load 0x00A3. Check: slot 1 shows `seg_n`=0x3F (dash), slot 0 shows 0x30.
- With `LEADING_ZERO_BLANK_EN`, load 0x0070. Check: digits 3 and 2 keep `an_n`=1111 through their slots, digit 1 shows 0x78, digit 0 shows 0x40. Load 0x0000: only digit 0 lit.
- Assert `load` with 0x9999 at `cnt`=5 of slot 2, preloaded 0x1234. Check: `seg_n` changes 0x24→0x10 one edge later, and `an_n`/`cnt` sequence is unbroken.
- Assert `rst` together with `load` mid-DRIVE. Check: all outputs go to reset values, `sh_dig` reads 0, and digit 0 shows 0x40 after the blank phase.
